// File: rtl/pattern_player_pkg.sv
// Shared types for the pattern player: FSM state encoding and the
// layout of one pattern-memory entry at the default vector widths.
package pattern_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int PP_NINPUTS  = 5;
    localparam int PP_NOUTPUTS = 2;

    // One stored pattern, packed most-significant first as {pi, xpct, mask}.
    typedef struct packed {
        logic [PP_NINPUTS-1:0]  pi;
        logic [PP_NOUTPUTS-1:0] xpct;
        logic [PP_NOUTPUTS-1:0] mask;
    } pat_entry_t;

    function automatic int entry_width(input int ninputs, input int noutputs);
        return ninputs + 2 * noutputs;
    endfunction

endpackage

// File: rtl/pattern_player_mem.sv
// Pattern storage: single write port, registered read port, no reset.
// Contents are undefined until loaded.
module pattern_mem #(
    parameter int  DEPTH = 16,
    parameter int  W     = 9,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Write and registered read share the clock; read returns pre-write data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pattern_player.sv
// Pattern player: applies stored stimulus to a combinational block, waits
// SETTLE_CYC cycles, compares masked responses and accumulates results.
// Handshake: start is sampled only in IDLE (ignored while busy); done and
// fail_valid are single-cycle pulses with no backpressure.
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter int NINPUTS    = PP_NINPUTS,
    parameter int NOUTPUTS   = PP_NOUTPUTS,
    parameter int DEPTH      = 16,
    parameter int SETTLE_CYC = 2,
    parameter int CNTW       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [NINPUTS-1:0]         ld_pi,
    input  logic [NOUTPUTS-1:0]        ld_xpct,
    input  logic [NOUTPUTS-1:0]        ld_mask,
    input  logic [$clog2(DEPTH):0]     pat_count,
    input  logic                       start,
    output logic [NINPUTS-1:0]         pi,
    input  logic [NOUTPUTS-1:0]        po,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   pat_idx,
    output logic                       fail_valid,
    output logic [NOUTPUTS-1:0]        fail_bits,
    output logic [CNTW-1:0]            fail_count,
    output logic [$clog2(DEPTH)-1:0]   first_fail,
    output logic                       any_fail,
    output state_t                     state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_width(NINPUTS, NOUTPUTS);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [NINPUTS-1:0]  pi;
        logic [NOUTPUTS-1:0] xpct;
        logic [NOUTPUTS-1:0] mask;
    } entry_t;

    state_t                state_d;
    entry_t                rd_entry;
    logic [NOUTPUTS-1:0]   xpct_q;
    logic [NOUTPUTS-1:0]   mask_q;
    logic [NOUTPUTS-1:0]   diff;
    logic [SW-1:0]         settle_cnt;
    logic [AW:0]           last_q;
    logic [AW:0]           count_clamped;
    logic                  last_pat;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic                  wr_en;

    // The memory read for pattern k is issued one cycle ahead (at start or
    // in the previous MEASURE) so its data is ready during APPLY.
    pattern_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ld_addr),
        .wr_data ({ld_pi, ld_xpct, ld_mask}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_entry)
    );

    assign count_clamped = (pat_count > DEPTH_C) ? DEPTH_C : pat_count;
    assign last_pat      = ({1'b0, pat_idx} == last_q);
    assign diff          = (po ^ xpct_q) & mask_q;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);

    // Next state plus memory-port control.
    always_comb begin
        state_d = state;
        rd_en   = 1'b0;
        rd_addr = pat_idx + AW'(1);
        wr_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                wr_en   = ld_en;
                rd_addr = '0;
                if (start) begin
                    if (pat_count != '0) begin
                        state_d = ST_APPLY;
                        rd_en   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_APPLY:   state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (last_pat) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_APPLY;
                    rd_en   = 1'b1;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Stimulus, comparator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pi         <= '0;
            xpct_q     <= '0;
            mask_q     <= '0;
            settle_cnt <= '0;
            pat_idx    <= '0;
            last_q     <= '0;
            fail_valid <= 1'b0;
            fail_bits  <= '0;
            fail_count <= '0;
            first_fail <= '0;
            any_fail   <= 1'b0;
        end else begin
            fail_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pat_idx    <= '0;
                        last_q     <= count_clamped - (AW+1)'(1);
                        fail_bits  <= '0;
                        fail_count <= '0;
                        first_fail <= '0;
                        any_fail   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    pi         <= rd_entry.pi;
                    xpct_q     <= rd_entry.xpct;
                    mask_q     <= rd_entry.mask;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
                ST_MEASURE: begin
                    if (diff != '0) begin
                        fail_valid <= 1'b1;
                        fail_bits  <= diff;
                        if (fail_count != '1) begin
                            fail_count <= fail_count + CNTW'(1);
                        end
                        if (!any_fail) begin
                            first_fail <= pat_idx;
                            any_fail   <= 1'b1;
                        end
                    end
                    if (!last_pat) begin
                        pat_idx <= pat_idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player: stimulus pushes expected fail events
// and end-of-run records; a negedge monitor pops and compares them.
module tb_pattern_player;
  import pattern_player_pkg::*;

  localparam int NI     = 5;
  localparam int NO     = 2;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 2;
  localparam int CNTW   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ld_en = 1'b0;
  logic [3:0]     ld_addr = '0;
  logic [NI-1:0]  ld_pi = '0;
  logic [NO-1:0]  ld_xpct = '0;
  logic [NO-1:0]  ld_mask = '0;
  logic [4:0]     pat_count = '0;
  logic           start = 1'b0;
  logic [NI-1:0]  pi;
  logic [NO-1:0]  po;
  logic           busy, done, fail_valid, any_fail;
  logic [3:0]     pat_idx, first_fail;
  logic [NO-1:0]  fail_bits;
  logic [CNTW-1:0] fail_count;
  state_t         state;

  // clock / reset
  always #5 clk = ~clk;

  pattern_player #(
    .NINPUTS(NI), .NOUTPUTS(NO), .DEPTH(DEPTH), .SETTLE_CYC(SETTLE), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_pi(ld_pi),
    .ld_xpct(ld_xpct), .ld_mask(ld_mask), .pat_count(pat_count), .start(start),
    .pi(pi), .po(po), .busy(busy), .done(done), .pat_idx(pat_idx),
    .fail_valid(fail_valid), .fail_bits(fail_bits), .fail_count(fail_count),
    .first_fail(first_fail), .any_fail(any_fail), .state(state)
  );

  // block under test: reference alu, alu with zout[1] stuck at 1, or
  // reference alu with the response to 10011 forced
  int         mode = 0;
  logic [1:0] p4_force = 2'b00;

  function automatic logic [1:0] alu_ref(input logic [4:0] v);
    case (v)
      5'b11101: return 2'b10;
      5'b01101: return 2'b00;
      5'b01111: return 2'b01;
      5'b00111: return 2'b00;
      5'b10011: return 2'b01;
      default:  return 2'b00;
    endcase
  endfunction

  always_comb begin
    po = alu_ref(pi);
    case (mode)
      1:       po = alu_ref(pi) | 2'b10;
      2:       po = (pi == 5'b10011) ? p4_force : alu_ref(pi);
      default: po = alu_ref(pi);
    endcase
  end

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_edge = 0;
  int          done_seen = 0;
  logic [1:0]  exp_q[$];
  logic [22:0] done_q[$];   // {latency[15:0], fail_count[1:0], first_fail[3:0], any_fail}
  logic [1:0]  e_bits;
  logic [22:0] e_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (fail_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fail_valid", 1, 0);
        end else begin
          e_bits = exp_q.pop_front();
          check("fail_bits", int'(fail_bits), int'(e_bits));
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e_done = done_q.pop_front();
          check("done_latency", cyc + 1 - start_edge, int'(e_done[22:7]));
          check("fail_count", int'(fail_count), int'(e_done[6:5]));
          check("first_fail", int'(first_fail), int'(e_done[4:1]));
          check("any_fail", int'(any_fail), int'(e_done[0]));
          check("fails_drained", exp_q.size(), 0);
          check("busy_at_done", int'(busy), 1);
        end
      end
    end
  end

  // driver tasks
  task automatic load(input int addr, input pat_entry_t ent);
    ld_en   = 1'b1;
    ld_addr = 4'(addr);
    ld_pi   = ent.pi;
    ld_xpct = ent.xpct;
    ld_mask = ent.mask;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic load_alu_set();
    load(0, '{pi: 5'b11101, xpct: 2'b10, mask: 2'b11});
    load(1, '{pi: 5'b01101, xpct: 2'b00, mask: 2'b11});
    load(2, '{pi: 5'b01111, xpct: 2'b01, mask: 2'b11});
    load(3, '{pi: 5'b00111, xpct: 2'b00, mask: 2'b11});
    load(4, '{pi: 5'b10011, xpct: 2'b00, mask: 2'b10});
  endtask

  // done is expected high at edge 1 + n_eff*(2+SETTLE) counted from the start edge
  task automatic launch(input int pc, input int n_eff, input int cnt, input int first,
                        input logic any);
    done_q.push_back({16'(1 + n_eff * (2 + SETTLE)), 2'(cnt), 4'(first), any});
    pat_count  = 5'(pc);
    start      = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_seen;
    n = 0;
    while (done_seen == base && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_seen == base) check({"done_timeout_", name}, 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pi", int'(pi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pat_idx", int'(pat_idx), 0);
    check("rst_fail_valid", int'(fail_valid), 0);
    check("rst_fail_bits", int'(fail_bits), 0);
    check("rst_fail_count", int'(fail_count), 0);
    check("rst_first_fail", int'(first_fail), 0);
    check("rst_any_fail", int'(any_fail), 0);
    check("rst_state", int'(state), int'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // correct alu: clean run, done at 21
    load_alu_set();
    mode = 0;
    launch(5, 5, 0, 0, 1'b0);
    wait_done("alu_good");
    check("pi_hold", int'(pi), 5'b10011);
    check("busy_idle", int'(busy), 0);

    // zout[1] stuck at 1: patterns 1..4 fail on bit 1, count saturates at 3
    mode = 1;
    repeat (4) exp_q.push_back(2'b10);
    launch(5, 5, 3, 1, 1'b1);
    wait_done("stuck");

    // masked bit: po=01 against 00/mask 10 passes, po=11 fails
    mode = 2;
    p4_force = 2'b01;
    launch(5, 5, 0, 0, 1'b0);
    wait_done("p4_masked");
    p4_force = 2'b11;
    exp_q.push_back(2'b10);
    launch(5, 5, 1, 4, 1'b1);
    wait_done("p4_fail");

    // six failing patterns: counter saturates
    mode = 0;
    for (int k = 0; k < 6; k++) load(k, '{pi: 5'(k), xpct: 2'b11, mask: 2'b11});
    repeat (6) exp_q.push_back(2'b11);
    launch(6, 6, 3, 0, 1'b1);
    wait_done("saturate");

    // zero-length run: one cycle of busy/done, results cleared
    launch(0, 0, 0, 0, 1'b0);
    check("zero_busy", int'(busy), 1);
    check("zero_done", int'(done), 1);
    @(negedge clk);
    check("zero_busy_after", int'(busy), 0);
    check("zero_done_after", int'(done), 0);

    // pat_count beyond DEPTH is clamped; all-zero masks never fail
    for (int k = 0; k < 16; k++) load(k, '{pi: 5'(k), xpct: 2'b11, mask: 2'b00});
    launch(31, 16, 0, 0, 1'b0);
    wait_done("clamp");

    // reset during SETTLE of pattern 2
    load_alu_set();
    mode = 1;
    exp_q.push_back(2'b10);
    pat_count  = 5'd5;
    start      = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_state", int'(state), int'(ST_SETTLE));
    check("pre_rst_pat_idx", int'(pat_idx), 2);
    rst = 1'b1;
    #1;
    check("rst_mid_pi", int'(pi), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_any_fail", int'(any_fail), 0);
    check("rst_mid_fail_count", int'(fail_count), 0);
    check("rst_mid_fails_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    begin
      int base;
      base = done_seen;
      repeat (30) @(negedge clk);
      check("no_done_after_rst", done_seen - base, 0);
    end

    // rerun from pattern 0 with memory intact; a load while busy is ignored
    repeat (4) exp_q.push_back(2'b10);
    launch(5, 5, 3, 1, 1'b1);
    load(1, '{pi: 5'b01101, xpct: 2'b10, mask: 2'b11});
    wait_done("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
